// File: rtl/mul_div_unit_if.sv
// Execute-stage <-> multiply/divide unit bus.
//   start : one-cycle operation request (pipeline -> unit)
//   ctrl  : operation code (pipeline -> unit)
//   A, B  : operands (pipeline -> unit)
//   busy  : operation in flight (unit -> pipeline)
//   HI/LO : architectural HI/LO registers (unit -> pipeline)
// master: the execute stage; slave: mul_div_unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, ctrl, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, ctrl, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// A start while idle latches op/operands; busy stays high for MUL_CYCLES or
// DIV_CYCLES cycles, and HI/LO are committed on the edge that drops busy.
// MTHI/MTLO write immediately. Starts while busy are ignored.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : mul_div_unit_if.slave (start, ctrl, A, B in; busy, HI, LO out)
// Optional feature: define MULDIV_MADD_EN to enable MADD (ctrl 6) and
// MADDU (ctrl 7); otherwise those codes are no-ops.
module mul_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic            clk,
  input logic            reset,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
  localparam logic [2:0] OpMadd  = 3'd6;
  localparam logic [2:0] OpMaddu = 3'd7;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  // Arithmetic on the latched operands; only sampled at the commit edge.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] div_n, div_d, quo, rem;
  logic [31:0] quo_res, rem_res;
  logic        signed_div;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands is the signed product.
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};

    signed_div = (op_q == OpDiv);
    a_neg      = signed_div & a_q[31];
    b_neg      = signed_div & b_q[31];
    a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag      = b_neg ? (~b_q + 32'd1) : b_q;

    // Single magnitude divider; divisor forced nonzero to keep it defined.
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, no negation.
    div_n = a_mag;
    div_d = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo   = div_n / div_d;
    rem   = div_n % div_d;

    quo_res = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
    rem_res = a_neg ? (~rem + 32'd1) : rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.ctrl)
            OpMult, OpMultu: begin
              op_d    = bus.ctrl;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CntW'(MUL_CYCLES);
              state_d = StBusy;
            end
            OpDiv, OpDivu: begin
              op_d    = bus.ctrl;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StBusy;
            end
            OpMthi: hi_d = bus.A;
            OpMtlo: lo_d = bus.A;
`ifdef MULDIV_MADD_EN
            OpMadd, OpMaddu: begin
              op_d    = bus.ctrl;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CntW'(MUL_CYCLES);
              state_d = StBusy;
            end
`endif
            default: ;
          endcase
        end
      end

      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          case (op_q)
            OpMult:  {hi_d, lo_d} = prod_s;
            OpMultu: {hi_d, lo_d} = prod_u;
            OpDiv, OpDivu: begin
              // Divide by zero leaves HI/LO untouched.
              if (b_q != 32'd0) begin
                lo_d = quo_res;
                hi_d = rem_res;
              end
            end
`ifdef MULDIV_MADD_EN
            // HI/LO are frozen while busy, so this base equals the value at start.
            OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
            default: ;
          endcase
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpMult;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StBusy);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit with a behavioural HI/LO model.
module tb_mul_div_unit;

  localparam int unsigned MulCycles = 5;
  localparam int unsigned DivCycles = 10;
`ifdef MULDIV_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic clk;
  logic reset;
  mul_div_unit_if bus ();

  mul_div_unit #(
    .MUL_CYCLES (MulCycles),
    .DIV_CYCLES (DivCycles)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural reference: latency and resulting HI/LO for one operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, ps;
    longint unsigned ua, ub, acc;
    int              si, sj;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    ps  = sa * sb;
    eh  = m_hi;
    el  = m_lo;
    lat = 0;
    case (op)
      3'd0: begin lat = MulCycles; {eh, el} = ps; end
      3'd1: begin lat = MulCycles; {eh, el} = ua * ub; end
      3'd2: begin
        lat = DivCycles;
        if (b == 0) begin
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'h0;
        end else begin
          si = a;
          sj = b;
          el = si / sj;
          eh = si % sj;
        end
      end
      3'd3: begin
        lat = DivCycles;
        if (b != 0) begin
          el = a / b;
          eh = a % b;
        end
      end
      3'd4: eh = a;
      3'd5: el = a;
      3'd6: if (MaddEn) begin
        lat = MulCycles;
        acc = {m_hi, m_lo};
        acc = acc + longint'(ps);
        {eh, el} = acc;
      end
      default: if (MaddEn) begin
        lat = MulCycles;
        acc = {m_hi, m_lo};
        acc = acc + ua * ub;
        {eh, el} = acc;
      end
    endcase
  endtask

  // Issue one op; optionally keep start high with junk for 'hold' busy cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int          lat, n, h;
    logic [31:0] eh, el;
    model(op, a, b, lat, eh, el);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ctrl  = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    n = 0;
    h = hold;
    while (1) begin
      if (h > 0) begin
        h--;
        bus.start = 1'b1;
        bus.ctrl  = 3'($urandom_range(0, 7));
        bus.A     = $urandom;
        bus.B     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (!bus.busy || n >= 200) break;
      n++;
      if (n == 1) check_eq("frozen_hilo", {bus.HI, bus.LO}, {m_hi, m_lo});
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq($sformatf("busy_len op%0d", op), 64'(n), 64'(lat));
    m_hi = eh;
    m_lo = el;
    check_eq($sformatf("hi op%0d", op), 64'(bus.HI), 64'(m_hi));
    check_eq($sformatf("lo op%0d", op), 64'(bus.LO), 64'(m_lo));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    n_tests   = 0;
    n_fail    = 0;
    m_hi      = '0;
    m_lo      = '0;
    bus.start = 1'b0;
    bus.ctrl  = '0;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_hi", 64'(bus.HI), 64'(0));
    check_eq("rst_lo", 64'(bus.LO), 64'(0));

    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
    check_eq("mult_hi_const", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    check_eq("mult_lo_const", 64'(bus.LO), 64'h0000_0000_FFFF_FFF1);
    do_op(3'd3, 32'd100, 32'd7, 0);
    check_eq("divu_lo_const", 64'(bus.LO), 64'd14);
    check_eq("divu_hi_const", 64'(bus.HI), 64'd2);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check_eq("div_lo_const", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
    check_eq("div_hi_const", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    do_op(3'd4, 32'h1234_5678, 32'd0, 0);
    do_op(3'd5, 32'h9, 32'd0, 0);
    check_eq("mthi_const", 64'(bus.HI), 64'h1234_5678);
    do_op(3'd2, 32'd5, 32'd0, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    check_eq("multu_hi_const", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
    check_eq("multu_lo_const", 64'(bus.LO), 64'h1);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("div_ovf_lo", 64'(bus.LO), 64'h8000_0000);

    // MADDU carry across LO into HI; a no-op when the feature is absent.
    do_op(3'd5, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(3'd4, 32'd0, 32'd0, 0);
    do_op(3'd7, 32'd1, 32'd1, 0);
    do_op(3'd6, 32'hFFFF_FFFF, 32'd3, 0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20)) - 32'd10;
      do_op(rop, ra, rb, (rop <= 3'd3) ? int'($urandom_range(0, 3)) : 0);
    end

    // Reset in the 4th busy cycle of a divide kills the pending result.
    do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ctrl  = 3'd2;
    bus.A     = 32'd10;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    check_eq("midrst_busy", 64'(bus.busy), 64'(0));
    check_eq("midrst_hi", 64'(bus.HI), 64'(m_hi));
    check_eq("midrst_lo", 64'(bus.LO), 64'(m_lo));
    repeat (15) @(negedge clk);
    check_eq("post_rst_busy", 64'(bus.busy), 64'(0));
    check_eq("post_rst_hilo", {bus.HI, bus.LO}, 64'(0));
    do_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle multiply/divide responder that owns the HI/LO registers. It sits in the execute stage behind the pipeline's start/busy handshake. The execute stage raises start for one cycle with an operation and operands. This unit asserts busy for the configured latency, then commits the result to HI/LO. The pipeline stalls any HI/LO-related instruction while busy is high.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); must be >= 1
DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be >= 1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle operation request, sampled at posedge
ctrl  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD*, 7 MADDU* (*only with the optional feature)
A  input  32  rs operand / dividend / MTHI-MTLO source
B  input  32  rt operand / divisor
busy  output  1  registered; high while an operation is in flight
HI  output  32  registered HI register
LO  output  32  registered LO register

Behaviour:
- Reset (clk edge with reset=1): HI=0, LO=0, busy=0, internal counter=0, pending result discarded. Reset has priority over everything, including mid-operation.
- Idle is busy=0. Busy is busy=1 with counter > 0.
- start=1 while idle with ctrl in {0,1,2,3} (or {6,7} with the feature):
  - Operands and op are latched at that edge.
  - busy=1 from the next cycle.
  - Counter loads MUL_CYCLES or DIV_CYCLES.
- While busy, counter decrements every edge. On the edge where the counter goes 1->0:
  - HI/LO update to the result.
  - busy=0 in the same cycle that HI/LO first show the new value.
  - Total: start at edge N gives busy high for cycles N+1..N+L and new HI/LO visible from edge N+L.
- HI/LO keep their old values throughout busy. The result may be computed at start or iteratively; only commit timing is specified.
- MTHI/MTLO with start=1 while idle: HI (or LO) = A at that edge. busy stays 0, no latency.
- start=1 while busy: ignored completely. No restart, no HI/LO write. The pipeline re-presents start during stalls, and busy being registered prevents double launch.
- start=1 with an undefined ctrl (6/7 without the feature): no-op.
- MULT: {HI,LO} = signed(A)*signed(B), 64-bit. MULTU: unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIV special case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, unsigned remainder in HI.
- Divide by zero (B=0, DIV or DIVU): busy still runs for DIV_CYCLES. HI and LO are left unchanged at commit.
- Simultaneous completion edge and new start: start is ignored, because busy is still 1 during that cycle.

Optional Feature:
MULDIV_MADD_EN.
- Defined: ctrl 6 (MADD) computes {HI,LO} = {HI,LO} + signed(A)*signed(B). ctrl 7 (MADDU) computes {HI,LO} = {HI,LO} + unsigned(A)*unsigned(B).
- Arithmetic is 64-bit modulo 2^64 and uses MUL_CYCLES latency.
- The accumulator base is the HI/LO value at commit time, which equals the value at start, since HI/LO are frozen while busy.
- Not defined: ctrl 6/7 are no-ops (busy stays 0, HI/LO unchanged).

Test Plan:
- After reset: start MULT, A=0xFFFFFFFD, B=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy=0.
- DIVU A=100, B=7 -> busy 10 cycles, then LO=14, HI=2. Next, DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678, then next cycle MTLO A=0x9 -> HI=0x12345678, LO=0x9; busy never asserted. Then DIV A=5, B=0 -> busy 10 cycles, HI/LO unchanged.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF; hold start=1 with other operands for 3 cycles -> busy 5 cycles only; HI=0xFFFFFFFE, LO=0x00000001.
- DIV 10/3 started; assert reset at busy cycle 4 -> next cycle busy=0, HI=0, LO=0; no later commit.
- With MULDIV_MADD_EN: MTLO 0xFFFFFFFF, MTHI 0, then MADDU A=1, B=1 -> HI=1, LO=0. Without the macro, ctrl=7 leaves busy=0 and HI/LO unchanged.
